// File: rtl/wb_req_buffer.sv
// wb_req_buffer: pipelined Wishbone request FIFO, SPI slave side -> system master.
// Define WB_REQ_BUFFER_STATS_EN to add wb_hiwater_o (peak FIFO fill since reset).
module wb_req_buffer #(
  parameter int WB_ADDR_WIDTH   = 20,
  parameter int DATA_WIDTH      = 8,
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                     wb_clock_i,
  input  logic                     wb_reset_ni,
  input  logic [WB_ADDR_WIDTH-1:0] wb_s_addr_i,
  input  logic [DATA_WIDTH-1:0]    wb_s_data_i,
  output logic [DATA_WIDTH-1:0]    wb_s_data_o,
  input  logic                     wb_s_we_i,
  input  logic                     wb_s_cycle_i,
  input  logic                     wb_s_strobe_i,
  output logic                     wb_s_stall_o,
  output logic                     wb_s_ack_o,
  output logic [WB_ADDR_WIDTH-1:0] wb_m_addr_o,
  output logic [DATA_WIDTH-1:0]    wb_m_data_o,
  input  logic [DATA_WIDTH-1:0]    wb_m_data_i,
  output logic                     wb_m_we_o,
  output logic                     wb_m_cycle_o,
  output logic                     wb_m_strobe_o,
  input  logic                     wb_m_stall_i,
  input  logic                     wb_m_ack_i
`ifdef WB_REQ_BUFFER_STATS_EN
  ,
  output logic [$clog2(DEPTH):0]   wb_hiwater_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [WB_ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [DATA_WIDTH-1:0]    r_data [DEPTH];
  logic                     r_we   [DEPTH];

  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic [OW-1:0]         r_out;
  logic                  r_mcyc;
  logic                  r_sack;
  logic [DATA_WIDTH-1:0] r_sdata;

  logic          w_stall;
  logic          w_strobe;
  logic          w_push;
  logic          w_pop;
  logic          w_ack;
  logic [PW-1:0] w_head;

  assign w_stall  = (r_count == CW'(DEPTH));
  assign w_strobe = wb_s_cycle_i & (r_count != '0)
                  & (r_out < OW'(MAX_OUTSTANDING));
  assign w_push   = wb_s_cycle_i & wb_s_strobe_i & ~w_stall;
  assign w_pop    = w_strobe & ~wb_m_stall_i;
  assign w_ack    = wb_m_ack_i & r_mcyc & (r_out != '0);

  // When empty, keep showing the most recently popped entry.
  assign w_head = (r_count == '0) ? r_rptr - PW'(1) : r_rptr;

  assign wb_s_stall_o  = w_stall;
  assign wb_m_strobe_o = w_strobe;
  assign wb_m_addr_o   = r_addr[w_head];
  assign wb_m_data_o   = r_data[w_head];
  assign wb_m_we_o     = r_we[w_head];
  assign wb_m_cycle_o  = r_mcyc;
  assign wb_s_ack_o    = r_sack;
  assign wb_s_data_o   = r_sdata;

  // Request storage: write the incoming request at the tail.
  always_ff @(posedge wb_clock_i) begin
    if (!wb_reset_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
        r_we[i]   <= 1'b0;
      end
    end else if (w_push) begin
      r_addr[r_wptr] <= wb_s_addr_i;
      r_data[r_wptr] <= wb_s_data_i;
      r_we[r_wptr]   <= wb_s_we_i;
    end
  end

  // Pointers, fill count and in-flight count; dropping cycle aborts all.
  always_ff @(posedge wb_clock_i) begin
    if (!wb_reset_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_out   <= '0;
    end else if (!wb_s_cycle_i) begin
      r_rptr  <= r_wptr;
      r_count <= '0;
      r_out   <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + CW'(1);
      else if (!w_push && w_pop)
        r_count <= r_count - CW'(1);
      if (w_pop && !w_ack)
        r_out <= r_out + OW'(1);
      else if (!w_pop && w_ack)
        r_out <= r_out - OW'(1);
    end
  end

  // Master cycle: raised by a push, held while work remains.
  always_ff @(posedge wb_clock_i) begin
    if (!wb_reset_ni)
      r_mcyc <= 1'b0;
    else
      r_mcyc <= w_push
              | (wb_s_cycle_i & ((r_count != '0) | (r_out != '0)));
  end

  // Registered ack and read data back to the SPI side.
  always_ff @(posedge wb_clock_i) begin
    if (!wb_reset_ni) begin
      r_sack  <= 1'b0;
      r_sdata <= '0;
    end else begin
      r_sack <= w_ack;
      if (w_ack) r_sdata <= wb_m_data_i;
    end
  end

`ifdef WB_REQ_BUFFER_STATS_EN
  logic [CW-1:0] r_hiwater;

  assign wb_hiwater_o = r_hiwater;

  // Peak fill level; survives aborts, cleared only by reset.
  always_ff @(posedge wb_clock_i) begin
    if (!wb_reset_ni)
      r_hiwater <= '0;
    else if (r_count > r_hiwater)
      r_hiwater <= r_count;
  end
`endif

endmodule

// File: tb/tb_wb_req_buffer.sv
// tb_wb_req_buffer: randomized and directed bench for wb_req_buffer.
// Reference model keeps the request FIFO as a queue and counts in-flight work.
`timescale 1ns/1ps
module tb_wb_req_buffer;

  localparam int AW    = 20;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;
  localparam int HW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n   = 1'b0;
  logic [AW-1:0] s_addr  = '0;
  logic [DW-1:0] s_wdata = '0;
  logic          s_we    = 1'b0;
  logic          s_cyc   = 1'b0;
  logic          s_stb   = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  logic          m_stall = 1'b0;
  logic          m_ack   = 1'b0;

  wire [DW-1:0] wb_s_data_o;
  wire          wb_s_stall_o;
  wire          wb_s_ack_o;
  wire [AW-1:0] wb_m_addr_o;
  wire [DW-1:0] wb_m_data_o;
  wire          wb_m_we_o;
  wire          wb_m_cycle_o;
  wire          wb_m_strobe_o;
`ifdef WB_REQ_BUFFER_STATS_EN
  wire [HW-1:0] wb_hiwater_o;
`endif

  wb_req_buffer #(
    .WB_ADDR_WIDTH  (AW),
    .DATA_WIDTH     (DW),
    .DEPTH          (DEPTH),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .wb_clock_i   (clk),
    .wb_reset_ni  (rst_n),
    .wb_s_addr_i  (s_addr),
    .wb_s_data_i  (s_wdata),
    .wb_s_data_o  (wb_s_data_o),
    .wb_s_we_i    (s_we),
    .wb_s_cycle_i (s_cyc),
    .wb_s_strobe_i(s_stb),
    .wb_s_stall_o (wb_s_stall_o),
    .wb_s_ack_o   (wb_s_ack_o),
    .wb_m_addr_o  (wb_m_addr_o),
    .wb_m_data_o  (wb_m_data_o),
    .wb_m_data_i  (m_rdata),
    .wb_m_we_o    (wb_m_we_o),
    .wb_m_cycle_o (wb_m_cycle_o),
    .wb_m_strobe_o(wb_m_strobe_o),
    .wb_m_stall_i (m_stall),
    .wb_m_ack_i   (m_ack)
`ifdef WB_REQ_BUFFER_STATS_EN
    ,
    .wb_hiwater_o (wb_hiwater_o)
`endif
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          we;
  } req_t;

  wire [DW+3:0]  w_obs_ctl  = {wb_s_stall_o, wb_m_strobe_o,
                               wb_m_cycle_o, wb_s_ack_o, wb_s_data_o};
  wire [AW+DW:0] w_obs_head = {wb_m_addr_o, wb_m_data_o, wb_m_we_o};
  wire [AW+DW+3:0] w_obs_all = {w_obs_ctl, w_obs_head};

  // Reference model state
  req_t          q[$];
  int            mout   = 0;
  logic          mcyc   = 1'b0;
  logic          msack  = 1'b0;
  logic [DW-1:0] msdata = '0;
  int            hiw    = 0;

  // Expected outputs for the current cycle
  logic          e_stall;
  logic          e_strobe;
  req_t          e_head;
  logic [DW+3:0] e_ctl;

  // Bench-side system responder
  int            sys_pend = 0;
  logic          ack_en   = 1'b0;
  logic [DW-1:0] rdq[$];

  int checks = 0;
  int errors = 0;

  task automatic predict();
    e_stall  = (q.size() == DEPTH);
    e_strobe = s_cyc && (q.size() != 0) && (mout < MAXO);
    if (q.size() != 0) e_head = q[0];
    e_ctl = {e_stall, e_strobe, mcyc, msack, msdata};
  endtask

  task automatic drive_sys();
    m_ack   = ack_en && (sys_pend > 0);
    m_rdata = (rdq.size() != 0) ? rdq[0] : DW'($urandom);
  endtask

  task automatic advance();
    logic push, pop, ack;
    int   n0, o0;
    req_t r;
    push = s_cyc && s_stb && !e_stall;
    pop  = e_strobe && !m_stall;
    ack  = m_ack && mcyc && (mout != 0);
    n0   = q.size();
    o0   = mout;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      mout = 0; mcyc = 1'b0; msack = 1'b0; msdata = '0; hiw = 0;
    end else begin
      if (n0 > hiw) hiw = n0;
      msack = ack;
      if (ack) msdata = m_rdata;
      if (!s_cyc) begin
        q.delete();
        mout = 0;
        mcyc = 1'b0;
      end else begin
        if (pop) void'(q.pop_front());
        if (push) begin
          r.a = s_addr; r.d = s_wdata; r.we = s_we;
          q.push_back(r);
        end
        mout = mout + int'(pop) - int'(ack);
        mcyc = push || (n0 != 0) || (o0 != 0);
      end
      if (pop) sys_pend++;
      if (m_ack && sys_pend > 0) begin
        sys_pend--;
        if (rdq.size() != 0) void'(rdq.pop_front());
      end
    end
    #1;
  endtask

  task automatic idle();
    rst_n = 1'b1; s_cyc = 1'b0; s_stb = 1'b0;
    m_ack = 1'b0; m_stall = 1'b0;
    predict();
    advance();
    sys_pend = 0; ack_en = 1'b0; rdq.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      predict();
      advance();
    end
    rst_n = 1'b1; s_cyc = 1'b1;
    predict();
    @(negedge clk);
    checks++;
    if (w_obs_all !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", w_obs_all);
    end
    checks++;
    if (w_obs_ctl !== e_ctl) begin
      errors++;
      $display("FAIL reset_ctl got %h want %h", w_obs_ctl, e_ctl);
    end
    advance();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst_n   = ($urandom_range(0, 149) != 0);
      s_cyc   = ($urandom_range(0, 29) != 0);
      s_stb   = $urandom_range(0, 1) == 1;
      s_we    = $urandom_range(0, 1) == 1;
      s_addr  = AW'($urandom);
      s_wdata = DW'($urandom);
      m_stall = ($urandom_range(0, 2) == 0);
      m_ack   = $urandom_range(0, 1) == 1;
      m_rdata = DW'($urandom);
      predict();
      @(negedge clk);
      checks++;
      if (w_obs_ctl !== e_ctl) begin
        errors++;
        $display("FAIL rand_ctl c=%0d got %h want %h", c, w_obs_ctl, e_ctl);
      end
      if (q.size() != 0) begin
        checks++;
        if (w_obs_head !== e_head) begin
          errors++;
          $display("FAIL rand_head c=%0d got %h want %h", c, w_obs_head, e_head);
        end
      end
      advance();
    end
    idle();
  endtask

  task automatic test_single_write();
    int acks = 0;
    ack_en = 1'b1; m_stall = 1'b0;
    for (int c = 0; c < 6; c++) begin
      s_cyc = 1'b1; s_stb = (c == 0);
      s_addr = 20'h12345; s_wdata = 8'hA5; s_we = 1'b1;
      drive_sys();
      predict();
      @(negedge clk);
      checks++;
      if (w_obs_ctl !== e_ctl) begin
        errors++;
        $display("FAIL single_ctl c=%0d got %h want %h", c, w_obs_ctl, e_ctl);
      end
      if (wb_s_ack_o) acks++;
      if (c == 1) begin
        checks++;
        if ({wb_m_strobe_o, w_obs_head} !== {1'b1, 20'h12345, 8'hA5, 1'b1}) begin
          errors++;
          $display("FAIL single_issue got %b/%h want 1/%h",
                   wb_m_strobe_o, w_obs_head, {20'h12345, 8'hA5, 1'b1});
        end
      end
      if (c == 3) begin
        checks++;
        if (wb_s_ack_o !== 1'b1) begin
          errors++;
          $display("FAIL single_ack got %b want 1", wb_s_ack_o);
        end
      end
      if (c == 4) begin
        checks++;
        if ({wb_m_cycle_o, acks} !== {1'b0, 32'd1}) begin
          errors++;
          $display("FAIL single_drop cyc=%b acks=%0d want 0/1", wb_m_cycle_o, acks);
        end
      end
      advance();
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] sent[$];
    logic [AW-1:0] seen[$];
    int acks = 0;
    ack_en = 1'b1;
    for (int c = 0; c < 30; c++) begin
      s_cyc = 1'b1; s_we = 1'b1;
      m_stall = (c < 8);
      s_addr = AW'($urandom); s_wdata = DW'($urandom);
      s_stb = (sent.size() < 6);
      drive_sys();
      predict();
      if (s_stb && !e_stall) sent.push_back(s_addr);
      @(negedge clk);
      checks++;
      if (w_obs_ctl !== e_ctl) begin
        errors++;
        $display("FAIL b2b_ctl c=%0d got %h want %h", c, w_obs_ctl, e_ctl);
      end
      if (q.size() != 0) begin
        checks++;
        if (w_obs_head !== e_head) begin
          errors++;
          $display("FAIL b2b_head c=%0d got %h want %h", c, w_obs_head, e_head);
        end
      end
      if (wb_m_strobe_o && !m_stall) seen.push_back(wb_m_addr_o);
      if (wb_s_ack_o) acks++;
      if (c == 7) begin
        checks++;
        if (wb_s_stall_o !== 1'b1) begin
          errors++;
          $display("FAIL b2b_full got %b want 1", wb_s_stall_o);
        end
      end
      advance();
    end
    checks++;
    if (seen.size() != 6 || acks != 6) begin
      errors++;
      $display("FAIL b2b_count issued=%0d acks=%0d want 6/6", seen.size(), acks);
    end
    for (int i = 0; i < seen.size() && i < sent.size(); i++) begin
      checks++;
      if (seen[i] !== sent[i]) begin
        errors++;
        $display("FAIL b2b_order i=%0d got %h want %h", i, seen[i], sent[i]);
      end
    end
    idle();
  endtask

  task automatic test_reads();
    logic [DW-1:0] tbl[3];
    int k = 0;
    tbl[0] = 8'h3C; tbl[1] = 8'hC3; tbl[2] = 8'h5A;
    for (int i = 0; i < 3; i++) rdq.push_back(tbl[i]);
    ack_en = 1'b1; m_stall = 1'b0;
    for (int c = 0; c < 16; c++) begin
      s_cyc = 1'b1; s_stb = (c < 3); s_we = 1'b0;
      s_addr = AW'($urandom);
      drive_sys();
      predict();
      @(negedge clk);
      checks++;
      if (w_obs_ctl !== e_ctl) begin
        errors++;
        $display("FAIL rd_ctl c=%0d got %h want %h", c, w_obs_ctl, e_ctl);
      end
      if (wb_s_ack_o && k < 3) begin
        checks++;
        if (wb_s_data_o !== tbl[k]) begin
          errors++;
          $display("FAIL rd_data k=%0d got %h want %h", k, wb_s_data_o, tbl[k]);
        end
        k++;
      end
      advance();
    end
    checks++;
    if (k != 3) begin
      errors++;
      $display("FAIL rd_acks got %0d want 3", k);
    end
    idle();
  endtask

  task automatic test_outstanding();
    int acc = 0;
    int acks = 0;
    m_stall = 1'b0;
    for (int c = 0; c < 30; c++) begin
      ack_en = (c >= 12);
      s_cyc = 1'b1; s_stb = (c < 4); s_we = 1'b1;
      s_addr = AW'($urandom); s_wdata = DW'($urandom);
      drive_sys();
      predict();
      @(negedge clk);
      checks++;
      if (w_obs_ctl !== e_ctl) begin
        errors++;
        $display("FAIL out_ctl c=%0d got %h want %h", c, w_obs_ctl, e_ctl);
      end
      if (wb_m_strobe_o) acc++;
      if (wb_s_ack_o) acks++;
      if (c == 11) begin
        checks++;
        if (acc != 2 || wb_m_strobe_o !== 1'b0) begin
          errors++;
          $display("FAIL out_limit issued=%0d stb=%b want 2/0", acc, wb_m_strobe_o);
        end
      end
      advance();
    end
    checks++;
    if (acc != 4 || acks != 4) begin
      errors++;
      $display("FAIL out_resume issued=%0d acks=%0d want 4/4", acc, acks);
    end
    idle();
  endtask

  task automatic test_abort();
    for (int c = 0; c < 9; c++) begin
      s_cyc = (c != 5);
      s_stb = (c == 0) || (c >= 2 && c <= 4);
      m_stall = (c >= 2 && c <= 5);
      m_ack = (c == 6);
      s_addr = AW'($urandom); s_wdata = DW'($urandom);
      m_rdata = DW'($urandom);
      predict();
      @(negedge clk);
      checks++;
      if (w_obs_ctl !== e_ctl) begin
        errors++;
        $display("FAIL abort_ctl c=%0d got %h want %h", c, w_obs_ctl, e_ctl);
      end
      if (c == 6) begin
        checks++;
        if ({wb_m_cycle_o, wb_m_strobe_o} !== 2'b00) begin
          errors++;
          $display("FAIL abort_clear got %b%b want 00", wb_m_cycle_o, wb_m_strobe_o);
        end
      end
      if (c == 7) begin
        checks++;
        if ({wb_s_ack_o, wb_m_strobe_o} !== 2'b00) begin
          errors++;
          $display("FAIL abort_late_ack got %b%b want 00", wb_s_ack_o, wb_m_strobe_o);
        end
      end
      advance();
    end
    idle();
  endtask

  task automatic test_stray_reset();
    for (int c = 0; c < 9; c++) begin
      rst_n = (c != 7);
      s_cyc = 1'b1;
      s_stb = (c == 2) || (c >= 4 && c <= 7);
      m_stall = (c == 2);
      m_ack = (c <= 1) || (c == 3);
      s_addr = AW'($urandom); s_wdata = DW'($urandom);
      s_we = 1'b1; m_rdata = DW'($urandom);
      if (c == 8) s_stb = 1'b0;
      predict();
      @(negedge clk);
      checks++;
      if (w_obs_ctl !== e_ctl) begin
        errors++;
        $display("FAIL stray_ctl c=%0d got %h want %h", c, w_obs_ctl, e_ctl);
      end
      if (c == 2 || c == 4) begin
        checks++;
        if (wb_s_ack_o !== 1'b0) begin
          errors++;
          $display("FAIL stray_ack c=%0d got %b want 0", c, wb_s_ack_o);
        end
      end
`ifdef WB_REQ_BUFFER_STATS_EN
      if (c == 6) begin
        checks++;
        if (wb_hiwater_o !== HW'(4)) begin
          errors++;
          $display("FAIL hiwater_peak got %0d want 4", wb_hiwater_o);
        end
      end
      if (c == 8) begin
        checks++;
        if (wb_hiwater_o !== '0) begin
          errors++;
          $display("FAIL hiwater_reset got %0d want 0", wb_hiwater_o);
        end
      end
`endif
      if (c == 8) begin
        checks++;
        if (w_obs_all !== '0) begin
          errors++;
          $display("FAIL stray_reset_outputs got %h want 0", w_obs_all);
        end
      end
      advance();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_random();
    test_single_write();
    test_back_to_back();
    test_reads();
    test_outstanding();
    test_abort();
    test_stray_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
